// File: rtl/ex_mem_pkg.sv
// Shared bus widths, control encodings and the pipeline-register action type
// used by the inter-stage registers of the 5-stage core.
package ex_mem_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int ALU_OP_BUS_W   = 8;
  localparam int CNT_BUS_W      = 2;

  localparam int NOP_REG_ADDR = 0;
  localparam int EXE_NOP_OP   = 0;

  localparam int STALL_W   = 6;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2,
    ACT_HOLD   = 2'd3
  } pipe_act_e;

endpackage

// File: rtl/ex_mem_pipe_reg_ctl.sv
// Decodes reset and the stall bits of a stage and its successor into the
// action a pipeline register takes on the next edge.
module pipe_reg_ctl
  import ex_mem_pkg::*;
(
  input  logic      i_rst,
  input  logic      i_stall_self,
  input  logic      i_stall_next,
  output pipe_act_e o_act
);

  // Stage stalled while its successor runs: successor must see a bubble.
  // Self running with successor stalled is illegal and resolves to load.
  always_comb begin
    o_act = ACT_HOLD;
    if (i_rst == RST_ENABLE)
      o_act = ACT_CLEAR;
    else if (i_stall_self == STOP && i_stall_next == NO_STOP)
      o_act = ACT_BUBBLE;
    else if (i_stall_self == NO_STOP)
      o_act = ACT_LOAD;
    else
      o_act = ACT_HOLD;
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: forwards EX results to MEM and returns the
// two-cycle MADD/MSUB accumulator state to EX while EX is stalled.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = REG_BUS_W,
  parameter int REG_ADDR_W = REG_ADDR_BUS_W,
  parameter int ALUOP_W    = ALU_OP_BUS_W,
  parameter int CNT_W      = CNT_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
);

  pipe_act_e w_act;

  logic [REG_ADDR_W-1:0] r_wd_p1;
  logic                  r_wreg_p1;
  logic [DATA_W-1:0]     r_wdata_p1;
  logic [DATA_W-1:0]     r_hi_p1;
  logic [DATA_W-1:0]     r_lo_p1;
  logic                  r_whilo_p1;
  logic [ALUOP_W-1:0]    r_aluop_p1;
  logic [DATA_W-1:0]     r_mem_addr_p1;
  logic [DATA_W-1:0]     r_reg2_p1;
  logic [2*DATA_W-1:0]   r_hilo_temp_p1;
  logic [CNT_W-1:0]      r_cnt_p1;

  pipe_reg_ctl u_ctl (
    .i_rst        (rst),
    .i_stall_self (stall[STALL_EX]),
    .i_stall_next (stall[STALL_MEM]),
    .o_act        (w_act)
  );

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk) begin
    unique case (w_act)
      ACT_CLEAR, ACT_BUBBLE: begin
        r_wd_p1       <= REG_ADDR_W'(NOP_REG_ADDR);
        r_wreg_p1     <= WRITE_DISABLE;
        r_wdata_p1    <= '0;
        r_hi_p1       <= '0;
        r_lo_p1       <= '0;
        r_whilo_p1    <= WRITE_DISABLE;
        r_aluop_p1    <= ALUOP_W'(EXE_NOP_OP);
        r_mem_addr_p1 <= '0;
        r_reg2_p1     <= '0;
      end
      ACT_LOAD: begin
        r_wd_p1       <= ex_wd;
        r_wreg_p1     <= ex_wreg;
        r_wdata_p1    <= ex_wdata;
        r_hi_p1       <= ex_hi;
        r_lo_p1       <= ex_lo;
        r_whilo_p1    <= ex_whilo;
        r_aluop_p1    <= ex_aluop;
        r_mem_addr_p1 <= ex_mem_addr;
        r_reg2_p1     <= ex_reg2;
      end
      ACT_HOLD: ;
    endcase
  end

  // ---- EX -> EX feedback: accumulator kept only while EX sits in a bubble ----
  always_ff @(posedge clk) begin
    unique case (w_act)
      ACT_CLEAR, ACT_LOAD: begin
        r_hilo_temp_p1 <= '0;
        r_cnt_p1       <= '0;
      end
      ACT_BUBBLE: begin
        r_hilo_temp_p1 <= ex_hilo_temp;
        r_cnt_p1       <= ex_cnt;
      end
      ACT_HOLD: ;
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE)
      assert (!(stall[STALL_EX] == NO_STOP && stall[STALL_MEM] == STOP))
        else $error("ex_mem: illegal stall vector %b (EX released before MEM)", stall);
  end
`endif

  assign mem_wd       = r_wd_p1;
  assign mem_wreg     = r_wreg_p1;
  assign mem_wdata    = r_wdata_p1;
  assign mem_hi       = r_hi_p1;
  assign mem_lo       = r_lo_p1;
  assign mem_whilo    = r_whilo_p1;
  assign mem_aluop    = r_aluop_p1;
  assign mem_mem_addr = r_mem_addr_p1;
  assign mem_reg2     = r_reg2_p1;
  assign hilo_temp_o  = r_hilo_temp_p1;
  assign cnt_o        = r_cnt_p1;

endmodule
